// File: rtl/cpu_info_pkg.sv
// rtl/cpu_info_pkg.sv - shared constants, encodings and ASCII helpers for the CPU info printer
package cpu_info_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    // One entry per field of the printed line, in emission order.
    typedef enum logic [3:0] {
        F_CARET,
        F_TIME,
        F_AT,
        F_PC,
        F_COLON,
        F_SP0,
        F_TAG,
        F_LOC,
        F_SP1,
        F_LT,
        F_EQ,
        F_SP2,
        F_DATA,
        F_HASH
    } field_t;

    // Lowercase hex digit: '0'..'9' then 'a'..'f' (8'h57 + 10 = 8'h61).
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

endpackage

// File: rtl/cpu_info_printer_bin2bcd.sv
// rtl/cpu_info_printer_bin2bcd.sv - sequential double-dabble converter, one input bit per cycle
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [14:0]   adj;

    // Add-3 correction on every BCD digit that would overflow on the next shift;
    // the top digit only needs its low three bits since bit 15 is shifted out.
    always_comb begin
        adj = '0;
        for (int k = 0; k < 3; k++) begin
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
        end
        adj[14:12] = (bcd[15:12] >= 4'd5) ? 3'(bcd[14:12] + 3'd3) : bcd[14:12];
    end

    // Load on start, then shift one bit per cycle for W cycles; done pulses once afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= din;
                bcd   <= '0;
                cnt   <= CW'(W);
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= {adj, shreg[W-1]};
                shreg <= shreg << 1;
                cnt   <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_info_printer.sv
// rtl/cpu_info_printer.sv - serialises retired-instruction records into the checker's ASCII stream
module cpu_info_printer
    import cpu_info_pkg::*;
#(
    parameter int         TIME_W    = 14,
    parameter int         TIME_MAX  = 9999,
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_type,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_grf,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char,
    output logic              char_valid,
    output logic              char_last,
    input  logic              out_ready
);

    state_t      state, nstate;
    logic        type_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  grf_q;
    field_t      field_q, nxt_field;
    logic [2:0]  idx_q, nxt_idx;
    logic [7:0]  nxt_char;
    logic        nxt_last;

    logic              accept, take;
    logic [TIME_W-1:0] time_sat;
    logic              conv_busy, conv_done;
    logic [15:0]       bcd;
    logic [2:0]        nt_m1;
    logic              ng_m1;
    logic [3:0]        grf_tens, grf_units;

    assign accept   = (state == IDLE) && in_valid;
    assign take     = char_valid && out_ready;
    assign time_sat = (in_time > TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : in_time;

    bin2bcd_seq #(.W(TIME_W)) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .din   (time_sat),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Digit counts (minus one) for leading-zero suppression, and grf split into decimal digits.
    always_comb begin
        if (bcd[15:12] != 4'd0)     nt_m1 = 3'd3;
        else if (bcd[11:8] != 4'd0) nt_m1 = 3'd2;
        else if (bcd[7:4] != 4'd0)  nt_m1 = 3'd1;
        else                        nt_m1 = 3'd0;
        ng_m1 = (grf_q >= 5'd10);
        if (grf_q >= 5'd30) begin
            grf_tens  = 4'd3;
            grf_units = 4'(grf_q - 5'd30);
        end else if (grf_q >= 5'd20) begin
            grf_tens  = 4'd2;
            grf_units = 4'(grf_q - 5'd20);
        end else if (grf_q >= 5'd10) begin
            grf_tens  = 4'd1;
            grf_units = 4'(grf_q - 5'd10);
        end else begin
            grf_tens  = 4'd0;
            grf_units = 4'(grf_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // Next-state logic.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (in_valid) nstate = CONV;
            CONV:    if (conv_done && !conv_busy) nstate = EMIT;
            EMIT:    if (take && char_last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Output logic: handshake and the character that follows the one currently presented.
    always_comb begin
        in_ready  = (state == IDLE);
        nxt_field = field_q;
        nxt_idx   = idx_q;
        case (field_q)
            F_CARET: begin nxt_field = F_TIME; nxt_idx = nt_m1; end
            F_TIME:  if (idx_q == 3'd0) nxt_field = F_AT; else nxt_idx = idx_q - 3'd1;
            F_AT:    begin nxt_field = F_PC; nxt_idx = 3'd7; end
            F_PC:    if (idx_q == 3'd0) nxt_field = F_COLON; else nxt_idx = idx_q - 3'd1;
            F_COLON: nxt_field = F_SP0;
            F_SP0:   nxt_field = F_TAG;
            F_TAG:   begin nxt_field = F_LOC; nxt_idx = type_q ? 3'd7 : {2'b00, ng_m1}; end
            F_LOC:   if (idx_q == 3'd0) nxt_field = F_SP1; else nxt_idx = idx_q - 3'd1;
            F_SP1:   nxt_field = F_LT;
            F_LT:    nxt_field = F_EQ;
            F_EQ:    nxt_field = F_SP2;
            F_SP2:   begin nxt_field = F_DATA; nxt_idx = 3'd7; end
            F_DATA:  if (idx_q == 3'd0) nxt_field = F_HASH; else nxt_idx = idx_q - 3'd1;
            default: nxt_field = F_HASH;
        endcase

        case (nxt_field)
            F_CARET: nxt_char = CH_CARET;
            F_TIME:  nxt_char = dec_char(bcd[{nxt_idx[1:0], 2'b00} +: 4]);
            F_AT:    nxt_char = CH_AT;
            F_PC:    nxt_char = hex_char(pc_q[{nxt_idx, 2'b00} +: 4]);
            F_COLON: nxt_char = CH_COLON;
            F_TAG:   nxt_char = type_q ? CH_STAR : CH_DOLLAR;
            F_LOC:   nxt_char = type_q ? hex_char(addr_q[{nxt_idx, 2'b00} +: 4])
                                       : dec_char(nxt_idx[0] ? grf_tens : grf_units);
            F_LT:    nxt_char = CH_LT;
            F_EQ:    nxt_char = CH_EQ;
            F_DATA:  nxt_char = hex_char(data_q[{nxt_idx, 2'b00} +: 4]);
            F_HASH:  nxt_char = CH_HASH;
            default: nxt_char = CH_SPACE;
        endcase
        nxt_last = (nxt_field == F_HASH);
    end

    // Record latch and registered character stream; a character advances only when taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            type_q     <= 1'b0;
            pc_q       <= '0;
            grf_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            field_q    <= F_CARET;
            idx_q      <= '0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            char_last  <= 1'b0;
        end else begin
            if (accept) begin
                type_q <= in_type;
                pc_q   <= in_pc;
                grf_q  <= in_grf;
                addr_q <= in_addr;
                data_q <= in_data;
            end
            if (state == CONV && conv_done) begin
                field_q    <= F_CARET;
                idx_q      <= '0;
                char       <= CH_CARET;
                char_valid <= 1'b1;
                char_last  <= 1'b0;
            end else if (state == EMIT && take) begin
                if (char_last) begin
                    char       <= IDLE_CHAR;
                    char_valid <= 1'b0;
                    char_last  <= 1'b0;
                end else begin
                    field_q   <= nxt_field;
                    idx_q     <= nxt_idx;
                    char      <= nxt_char;
                    char_last <= nxt_last;
                end
            end
        end
    end

endmodule
